pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
// - Consumer-side companion to the 50->12 MHz PLL: drives the PLL reset and watches its lock output.
// - Runs on refclk. Synchronizes the asynchronous lock output and requires lock to be stable before releasing downstream reset.
// - On loss of lock, re-resets the PLL with bounded retries.
// - Sits between the board reset/PLL and all 12 MHz-domain logic reset trees.
// PARAMETERS
// - RST_CYCLES     16      cycles pll_rst is held high per PLL reset attempt (>=2)
// - LOCK_TIMEOUT   50000   cycles allowed in WAIT_LOCK before retry (1 ms @ 50 MHz)
// - STABLE_CYCLES  1024    consecutive synced-locked cycles required before RUN
// - MAX_RETRY      3       failed attempts tolerated; attempt MAX_RETRY+1 failing -> FAIL
// - FREQ_WINDOW    1000    refclk cycles per frequency measurement window
// - FREQ_EXP       240     expected pll_clk rising edges per window (12 MHz / 50 MHz * 1000)
// - FREQ_TOL       2       allowed +/- deviation from FREQ_EXP
// PORTS
// - refclk       in   1   50 MHz reference clock; the only clock
// - rst          in   1   synchronous, active-high reset
// - pll_locked   in   1   PLL lock output, asynchronous to refclk
// - pll_clk      in   1   PLL output clock, sampled as data (used only with FREQ_CHECK_EN)
// - pll_rst      out  1   reset to PLL, active high
// - sys_rst      out  1   downstream reset, active high
// - ready        out  1   high only in RUN
// - fail         out  1   sticky; high in FAIL
// - retry_cnt    out  8   failed attempts since rst, saturating at 255
// - lost_cnt     out  8   RUN->lock-loss events since rst, saturating at 255
// - state_o      out  3   PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
// - freq_err     out  1   last completed window out of tolerance
// - edge_count   out  16  edge count of last completed window
// BEHAVIOUR
// - Reset values, held while rst=1:
//   - Outputs: pll_rst=1, sys_rst=1, ready=0, fail=0, counters=0, state=PLL_RST, freq_err=0, edge_count=0.
//   - Synchronizer flops: 0.
// - lock_s: pll_locked through 2 refclk flops. FSM sees only lock_s, so latency is 2 cycles.
// - PLL_RST: pll_rst=1, sys_rst=1. Timer counts RST_CYCLES, then -> WAIT_LOCK (timer cleared).
// - WAIT_LOCK: pll_rst=0, sys_rst=1.
//   - lock_s=1 -> STABLE.
//   - Timer reaches LOCK_TIMEOUT-1 without lock_s -> retry.
// - STABLE: pll_rst=0, sys_rst=1.
//   - Counts consecutive lock_s=1 cycles. Reaching STABLE_CYCLES -> RUN.
//   - lock_s=0 -> WAIT_LOCK with the timer restarted. Not a retry.
// - RUN: pll_rst=0, sys_rst=0, ready=1.
//   - lock_s=0 -> lost_cnt++, then PLL_RST. sys_rst=1 and ready=0 register in the same edge. Retry budget untouched.
//   - Entering RUN clears the attempt counter; retry_cnt (history) is kept.
// - Retry: retry_cnt++ and attempt++.
//   - attempt > MAX_RETRY -> FAIL.
//   - Otherwise -> PLL_RST.
// - FAIL: pll_rst=1, sys_rst=1, fail=1. Terminal until rst.
// - Simultaneous events:
//   - Timeout and lock_s rise in the same cycle: lock wins (-> STABLE).
//   - rst mid-operation: immediate return to reset values on the next edge.
// - Saturating counters never wrap. All timers are sized by $clog2 of their parameter.
// CONFIGURATION
// - Macro FREQ_CHECK_EN, defined:
//   - pll_clk is synchronized with 2 flops. Synced rising edges are counted over each FREQ_WINDOW window, counting only in RUN.
//   - At window end: edge_count <= count; freq_err <= |count-FREQ_EXP| > FREQ_TOL; counter restarts.
//   - Leaving RUN clears the window counter, but not edge_count or freq_err.
//   - freq_err is status only and does not change FSM state.
// - Macro FREQ_CHECK_EN, undefined: freq_err=0 and edge_count=0 constant; pll_clk unused; no counter logic.
// TESTING
// - Bench params: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2.
// - Normal bring-up: rst 3 cycles, pll_locked rises 10 cycles after pll_rst falls ->
//   - pll_rst high exactly 4 cycles.
//   - state STABLE 2 cycles after the rise.
//   - sys_rst falls and ready rises 8 cycles later.
//   - retry_cnt=0.
// - Lock glitch in STABLE: pll_locked low 1 cycle at STABLE count 5 ->
//   - back to WAIT_LOCK, then RUN only after 8 fresh stable cycles.
//   - retry_cnt stays 0.
// - Timeout/fail: pll_locked held 0 ->
//   - retry_cnt 1,2,3 at each 100-cycle timeout.
//   - after 3rd timeout state=FAIL, fail=1, pll_rst=1; persists until rst.
// - Lock loss in RUN: drop pll_locked ->
//   - 2 cycles later sys_rst=1, ready=0, lost_cnt=1, state=PLL_RST.
//   - relock reaches RUN again.
// - Mid-operation reset: assert rst during STABLE ->
//   - next edge all outputs at reset values.
//   - lost_cnt and retry_cnt = 0.
// - FREQ_CHECK_EN, FREQ_WINDOW=1000, in RUN:
//   - pll_clk 12 MHz -> edge_count within 238..242, freq_err=0.
//   - pll_clk 10 MHz -> edge_count ~200, freq_err=1.
//   - Without macro, freq_err and edge_count stay 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on refclk: drives pll_rst, qualifies lock, gates sys_rst, retries on failure.
// Optional pll_clk frequency monitor is built only when FREQ_CHECK_EN is defined.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned FREQ_WINDOW   = 1000,
  parameter int unsigned FREQ_EXP      = 240,
  parameter int unsigned FREQ_TOL      = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        pll_clk,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        ready,
  output logic        fail,
  output logic [7:0]  retry_cnt,
  output logic [7:0]  lost_cnt,
  output logic [2:0]  state_o,
  output logic        freq_err,
  output logic [15:0] edge_count
);

  localparam int unsigned RW = $clog2(RST_CYCLES);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT);
  localparam int unsigned TW = (RW > LW) ? RW : LW;
  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam int unsigned AW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] ATT_MAX     = AW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_stable;
  logic [AW-1:0] r_attempt;
  logic          r_lock_m;
  logic          r_lock_s;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_fail;
  logic [7:0]    r_retry_cnt;
  logic [7:0]    r_lost_cnt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_timer     <= '0;
      r_stable    <= '0;
      r_attempt   <= '0;
      r_lock_m    <= 1'b0;
      r_lock_s    <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_retry_cnt <= '0;
      r_lost_cnt  <= '0;
    end else begin
      r_lock_m <= pll_locked;
      r_lock_s <= r_lock_m;
      case (r_state)
        ST_PLL_RST: begin
          if (r_timer == RST_LAST) begin
            r_state   <= ST_WAIT_LOCK;
            r_timer   <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // lock is tested first so a lock arriving on the timeout cycle still wins
          if (r_lock_s) begin
            r_state  <= ST_STABLE;
            r_stable <= '0;
          end else if (r_timer == LOCK_LAST) begin
            if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
            r_attempt <= r_attempt + AW'(1);
            r_pll_rst <= 1'b1;
            r_timer   <= '0;
            if (r_attempt >= ATT_MAX) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state <= ST_PLL_RST;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_STABLE: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_timer <= '0;
          end else if (r_stable == STABLE_LAST) begin
            r_state   <= ST_RUN;
            r_attempt <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_stable <= r_stable + SW'(1);
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            if (r_lost_cnt != 8'hFF) r_lost_cnt <= r_lost_cnt + 8'd1;
            r_state   <= ST_PLL_RST;
            r_timer   <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: begin
          r_state   <= ST_PLL_RST;
          r_timer   <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;
  assign lost_cnt  = r_lost_cnt;
  assign state_o   = r_state;

`ifdef FREQ_CHECK_EN
  localparam int unsigned WW = (FREQ_WINDOW > 1) ? $clog2(FREQ_WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(FREQ_WINDOW - 1);
  localparam int unsigned   FREQ_HI  = FREQ_EXP + FREQ_TOL;

  logic          r_pclk_m;
  logic          r_pclk_s;
  logic          r_pclk_d;
  logic [WW-1:0] r_win;
  logic [15:0]   r_edges;
  logic [15:0]   r_edge_count;
  logic          r_freq_err;
  logic          w_rise;
  logic [15:0]   w_total;
  logic [31:0]   w_total32;

  assign w_rise    = r_pclk_s & ~r_pclk_d;
  assign w_total   = r_edges + {15'd0, w_rise};
  assign w_total32 = {16'd0, w_total};

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pclk_m     <= 1'b0;
      r_pclk_s     <= 1'b0;
      r_pclk_d     <= 1'b0;
      r_win        <= '0;
      r_edges      <= '0;
      r_edge_count <= '0;
      r_freq_err   <= 1'b0;
    end else begin
      r_pclk_m <= pll_clk;
      r_pclk_s <= r_pclk_m;
      r_pclk_d <= r_pclk_s;
      // window only runs in RUN; results of the last window survive leaving RUN
      if (r_state != ST_RUN) begin
        r_win   <= '0;
        r_edges <= '0;
      end else if (r_win == WIN_LAST) begin
        r_edge_count <= w_total;
        r_freq_err   <= (w_total32 > FREQ_HI) || ((w_total32 + FREQ_TOL) < FREQ_EXP);
        r_win        <= '0;
        r_edges      <= '0;
      end else begin
        r_win   <= r_win + WW'(1);
        r_edges <= w_total;
      end
    end
  end

  assign freq_err   = r_freq_err;
  assign edge_count = r_edge_count;
`else
  logic w_unused_pll_clk;
  assign w_unused_pll_clk = pll_clk;
  assign freq_err   = 1'b0;
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed bring-up/fault scenarios plus randomized
// lock traffic, all compared every cycle against a cycle-level behavioural model.
module tb_pll_lock_supervisor;

  localparam int RST_C = 4;
  localparam int TO    = 100;
  localparam int STB   = 8;
  localparam int MR    = 2;
  localparam int FW    = 1000;
  localparam int FE    = 240;
  localparam int FT    = 2;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        pll_locked = 1'b0;
  logic        pll_clk = 1'b0;
  logic        pll_rst, sys_rst, ready, fail, freq_err;
  logic [7:0]  retry_cnt, lost_cnt;
  logic [2:0]  state_o;
  logic [15:0] edge_count;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB), .MAX_RETRY(MR),
    .FREQ_WINDOW(FW), .FREQ_EXP(FE), .FREQ_TOL(FT)
  ) u_dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_clk(pll_clk),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt), .state_o(state_o),
    .freq_err(freq_err), .edge_count(edge_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state codes are the published state_o values.
  int m_st, m_tmr, m_cnt, m_att, m_retry, m_lost;
  int m_win, m_edges, m_ecount, m_ferr;
  bit m_lk[$];
  bit m_pq[$];
  int ratio = 12;
  int acc = 0;

  task automatic model_retry();
    if (m_retry < 255) m_retry++;
    m_att++;
    if (m_att > MR) m_st = 4;
    else begin m_st = 0; m_tmr = 0; end
  endtask

  task automatic model_step();
    int st0;
    bit lk;
    bit rise;
    if (rst) begin
      m_st = 0; m_tmr = 0; m_cnt = 0; m_att = 0; m_retry = 0; m_lost = 0;
      m_win = 0; m_edges = 0; m_ecount = 0; m_ferr = 0;
      m_lk = '{0, 0};
      m_pq = '{0, 0, 0};
      return;
    end
    st0 = m_st;
    // lock as seen after a two-stage delay
    lk = m_lk[0];
    m_lk.pop_front();
    m_lk.push_back(pll_locked);
    rise = m_pq[1] && !m_pq[0];
    m_pq.pop_front();
    m_pq.push_back(pll_clk);
`ifdef FREQ_CHECK_EN
    if (st0 != 3) begin
      m_win = 0; m_edges = 0;
    end else begin
      m_edges += int'(rise);
      m_win++;
      if (m_win == FW) begin
        m_ecount = m_edges;
        m_ferr = ((m_edges - FE) > FT || (FE - m_edges) > FT) ? 1 : 0;
        m_win = 0; m_edges = 0;
      end
    end
`endif
    case (st0)
      0: if (m_tmr == RST_C - 1) begin m_st = 1; m_tmr = 0; end else m_tmr++;
      1: if (lk) begin m_st = 2; m_cnt = 0; end
         else if (m_tmr == TO - 1) model_retry();
         else m_tmr++;
      2: if (!lk) begin m_st = 1; m_tmr = 0; end
         else if (m_cnt == STB - 1) begin m_st = 3; m_att = 0; end
         else m_cnt++;
      3: if (!lk) begin
           if (m_lost < 255) m_lost++;
           m_st = 0; m_tmr = 0;
         end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("state", state_o, m_st);
    chk("pll_rst", pll_rst, (m_st == 0 || m_st == 4) ? 1 : 0);
    chk("sys_rst", sys_rst, (m_st != 3) ? 1 : 0);
    chk("ready", ready, (m_st == 3) ? 1 : 0);
    chk("fail", fail, (m_st == 4) ? 1 : 0);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("lost_cnt", lost_cnt, m_lost);
    chk("freq_err", freq_err, m_ferr);
    chk("edge_count", edge_count, m_ecount);
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
  task automatic cyc(input bit rst_v, input bit lock_v);
    rst = rst_v;
    pll_locked = lock_v;
    acc = (acc + ratio) % 50;
    pll_clk = (acc < 25);
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    compare_all();
  endtask

  task automatic wait_state(input int tgt, input int budget, input bit lk, input string tag);
    for (int i = 0; i < budget && state_o != 3'(tgt); i++) cyc(1'b0, lk);
    chk(tag, state_o, tgt);
  endtask

  initial begin
    int n;
    int prev;
    int idx;
    int last_i;
    bit seen;
    int gaps[3];

    @(negedge refclk);
    repeat (3) cyc(1'b1, 1'b0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_state", state_o, 0);

    // pll_rst width after release, counting the cycle following the last reset edge
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      if (pll_rst) n++;
      else break;
    end
    chk("pll_rst_len", n, RST_C);

    repeat (9) cyc(1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      if (state_o == 3'd1) n++;
      else break;
    end
    chk("lock_latency", n, 2);
    chk("stable_entry", state_o, 2);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1);
      if (state_o == 3'd2) n++;
      else break;
    end
    chk("stable_len", n, STB);
    chk("run_ready", ready, 1);
    chk("run_sys_rst", sys_rst, 0);
    chk("run_retry", retry_cnt, 0);

    // lock loss while running
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (ready) n++;
      else break;
    end
    chk("loss_latency", n, 2);
    chk("loss_lost", lost_cnt, 1);
    chk("loss_state", state_o, 0);
    chk("loss_sys_rst", sys_rst, 1);
    wait_state(3, 200, 1'b1, "relock_run");

    // single-cycle glitch in STABLE
    cyc(1'b0, 1'b0);
    wait_state(2, 200, 1'b1, "glitch_pre_stable");
    repeat (4) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      if (state_o == 3'd1) seen = 1'b1;
    end
    chk("glitch_wait", seen, 1);
    wait_state(3, 40, 1'b1, "glitch_run");
    chk("glitch_retry", retry_cnt, 0);

    // reset asserted in STABLE
    cyc(1'b0, 1'b0);
    wait_state(2, 200, 1'b1, "mr_pre_stable");
    cyc(1'b1, 1'b1);
    chk("mr_state", state_o, 0);
    chk("mr_pll_rst", pll_rst, 1);
    chk("mr_sys_rst", sys_rst, 1);
    chk("mr_lost", lost_cnt, 0);
    chk("mr_retry", retry_cnt, 0);

    // lock never arrives: three timeouts end in FAIL
    prev = 0; idx = 0; last_i = 0;
    for (int i = 0; i < 600 && !fail; i++) begin
      cyc(1'b0, 1'b0);
      if (int'(retry_cnt) != prev) begin
        if (idx < 3) gaps[idx] = i - last_i;
        idx++;
        last_i = i;
        prev = int'(retry_cnt);
      end
    end
    chk("to_count", retry_cnt, 3);
    chk("to_gap2", gaps[1], RST_C + TO);
    chk("to_gap3", gaps[2], RST_C + TO);
    chk("to_fail", fail, 1);
    chk("to_state", state_o, 4);
    repeat (30) cyc(1'b0, 1'b1);
    chk("fail_sticky", state_o, 4);
    chk("fail_pll_rst", pll_rst, 1);

    // randomized lock traffic with occasional reset
    cyc(1'b1, 1'b0);
    for (int s = 0; s < 120; s++) begin
      int len;
      bit v;
      len = $urandom_range(1, 80);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) ratio = ($urandom_range(0, 1) == 1) ? 12 : 10;
      for (int i = 0; i < len; i++) cyc(($urandom_range(0, 299) == 0), v);
    end

    // long RUN intervals for the frequency monitor
    ratio = 12;
    cyc(1'b1, 1'b1);
    wait_state(3, 200, 1'b1, "freq_run");
    repeat (2100) cyc(1'b0, 1'b1);
`ifdef FREQ_CHECK_EN
    chk("f12_range", (edge_count >= 16'd238 && edge_count <= 16'd242) ? 1 : 0, 1);
    chk("f12_err", freq_err, 0);
`else
    chk("f12_ec_off", edge_count, 0);
    chk("f12_err_off", freq_err, 0);
`endif
    ratio = 10;
    repeat (2100) cyc(1'b0, 1'b1);
`ifdef FREQ_CHECK_EN
    chk("f10_count", edge_count, 200);
    chk("f10_err", freq_err, 1);
`else
    chk("f10_ec_off", edge_count, 0);
    chk("f10_err_off", freq_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
